// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory requester and its clients.
package mem_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 5;
  localparam int unsigned MEM_DATA_WIDTH = 32;

  // Requester FSM states
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StResp
  } mem_state_e;

  typedef struct packed {
    logic                      wr;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic                      wr;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } mem_rsp_t;

endpackage

// File: rtl/mem_requester.sv
// Single-outstanding initiator for a 1-cycle-latency synchronous memory.
// Takes one command over a valid/ready request channel, pulses the memory
// enable for one cycle, captures read data and returns a registered completion.
module mem_requester
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = MEM_DATA_WIDTH,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // request channel
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wr,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  // response channel
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_wr,
  output logic [ADDR_WIDTH-1:0]    rsp_addr,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  // memory port
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_out,
  input  logic                     mem_valid_out,
  // status
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  mem_state_e state_q, state_d;

  logic                     mem_en_d, mem_wr_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_data_in_d;
  logic                     rsp_valid_d, rsp_wr_d, rsp_err_d;
  logic [ADDR_WIDTH-1:0]    rsp_addr_d;
  logic [DATA_WIDTH-1:0]    rsp_rdata_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_d;

  // Only combinational output: ready is a pure state decode.
  assign req_ready = (state_q == StIdle);

  // Next-state and next-output decode; everything holds unless a state says otherwise.
  always_comb begin
    state_d       = state_q;
    mem_en_d      = mem_en;
    mem_wr_d      = mem_wr;
    mem_addr_d    = mem_addr;
    mem_data_in_d = mem_data_in;
    rsp_valid_d   = rsp_valid;
    rsp_wr_d      = rsp_wr;
    rsp_addr_d    = rsp_addr;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    err_count_d   = err_count;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          mem_en_d      = 1'b1;
          mem_wr_d      = req_wr;
          mem_addr_d    = req_addr;
          mem_data_in_d = req_wdata;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        // Memory samples the port at this closing edge; drop the enable pulse.
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
        if (mem_wr) begin
          rsp_wr_d    = 1'b1;
          rsp_addr_d  = mem_addr;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (mem_valid_out) begin
          rsp_rdata_d = mem_data_out;
          rsp_err_d   = 1'b0;
        end else begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          if (err_count != {ERR_CNT_WIDTH{1'b1}}) begin
            err_count_d = err_count + 1'b1;
          end
        end
        rsp_wr_d    = 1'b0;
        rsp_addr_d  = mem_addr;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; async reset abandons any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_addr    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      mem_en      <= mem_en_d;
      mem_wr      <= mem_wr_d;
      mem_addr    <= mem_addr_d;
      mem_data_in <= mem_data_in_d;
      rsp_valid   <= rsp_valid_d;
      rsp_wr      <= rsp_wr_d;
      rsp_addr    <= rsp_addr_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      err_count   <= err_count_d;
    end
  end

endmodule
